dma_multi: RTL
==============

// Module: dma_multi
// PURPOSE
//  Parametrised multi-channel DMA engine; successor to the single-channel OAM DMA.
//  Each channel copies 16-byte blocks from a 16-bit source to a 16-bit destination. Two modes: general (all blocks back-to-back) or hblank (one block per hblank rising edge).
//  Sits beside the CPU on the MMIO bus. Drives the shared external bus while dma_occupy_bus=1.
// PARAMETERS
//  NUM_CH       2         number of channels (1..4); lower index = higher priority
//  MMIO_BASE    16'hFF51  first register address; channel c owns MMIO_BASE+5c .. +5c+4
//  LEN_W        7         block-count field width; max transfer 2^LEN_W blocks
//  BLOCK_BYTES  16        bytes per block (power of 2, 2..256)
// PORTS
//  clk             in   1          system clock (4.19 MHz)
//  rst             in   1          synchronous reset, active-high
//  ct              in   2          T-cycle number within the machine cycle (0..3)
//  mmio_a          in   16         CPU address
//  mmio_din        in   8          CPU write data
//  mmio_wr         in   1          CPU write strobe; already qualified by the top-level decode
//  mmio_dout       out  8          register read data (combinational from mmio_a)
//  hblank          in   1          PPU hblank level; its rising edge is the trigger
//  dma_a           out  16         bus address
//  dma_dout        out  8          bus write data
//  dma_din         in   8          bus read data
//  dma_rd          out  1          bus read enable
//  dma_wr          out  1          bus write enable
//  dma_occupy_bus  out  1          DMA owns the bus for this machine cycle
//  ch_active       out  NUM_CH     per-channel busy flag
//  int_done        out  NUM_CH     one-clk pulse when a channel finishes or is cancelled
// BEHAVIOUR
//  Registers per channel c (offset from MMIO_BASE+5c):
//   +0 SRC_HI, +1 SRC_LO, +2 DST_HI, +3 DST_LO, +4 CTRL.
//   SRC_LO and DST_LO low log2(BLOCK_BYTES) bits are forced to 0.
//   CTRL write: [7]=mode (1=hblank), [LEN_W-1:0]=blocks-1.
//   CTRL read: {~active, remaining_blocks-1}; reads 8'hFF when idle.
//   SRC/DST read as 8'hFF. Unmapped offsets read 8'hFF.
//  Channel FSM, per channel: IDLE -> (CTRL write) -> PEND -> (bus granted) -> XFER -> (block done)
//   -> back to PEND if blocks remain, else IDLE. A general-mode PEND is eligible immediately.
//   An hblank-mode PEND becomes eligible only on an hblank rising edge seen while in PEND.
//  Arbitration: evaluated on the clk where ct==3. Grants the lowest-index eligible channel.
//   The granted channel holds the bus for one whole block; there is no pre-emption mid-block.
//  Byte timing, one byte per machine cycle:
//   - ct=0,1: dma_rd=1, dma_a=src.
//   - dma_din is latched on the clk edge where ct==1.
//   - ct=2,3: dma_wr=1, dma_a=dst, dma_dout=latched byte.
//   - src and dst both increment at the end of ct==3.
//  dma_occupy_bus=1 for every machine cycle of a block (all 4 T-cycles). It is 0 in all other cycles.
//  Addresses wrap modulo 2^16 (FFFF -> 0000). The block counter decrements after the last byte of each block.
//  Control writes, while a channel is active:
//   - CTRL write with [7]=0 to an active hblank-mode channel: cancel. The current block completes, then IDLE and an int_done pulse.
//   - Any other CTRL write while active: ignored.
//   - SRC/DST writes while active: ignored.
//  Simultaneous events:
//   - A CTRL write and an hblank edge in the same clk: the edge is not counted for that start.
//   - Two channels finishing on the same clk: both int_done bits pulse.
//  rst: all channels IDLE, counters 0, registers 0. All bus outputs, int_done and ch_active are 0, mmio_dout 8'hFF.
//   A reset in mid-block aborts the block and releases the bus on the next clk.
//  Latency: a general-mode CTRL write reaches its first dma_rd at the next ct==0 after the next ct==3.
// TESTING
//  1. Ch0 SRC=C000, DST=8000, CTRL=0x01 (2 blocks) -> 32 bytes copied in 32 M-cycles; ch_active[0] drops; one int_done[0] pulse.
//  2. Ch0 and ch1 started on the same clk, both general mode -> ch0's whole transfer completes before ch1's first dma_rd.
//  3. Ch1 CTRL=0x82 (hblank mode, 3 blocks), 3 hblank pulses -> exactly 16 bytes after each pulse; bus idle between pulses.
//  4. Hblank channel cancelled with CTRL=0x00 mid-block -> that block finishes (16 bytes); int_done pulse; CTRL reads 0xFF.
//  5. SRC=FFF0, DST=9FF0, 2 blocks -> second block reads from 0000..000F and writes to A000..A00F.
//  6. rst asserted at byte 5 of a block -> dma_occupy_bus=0 and dma_rd/dma_wr=0 next clk; all channels read CTRL=0xFF.

Source files
------------

// File: rtl/dma_multi.sv
// dma_multi: multi-channel block DMA engine sitting beside the CPU on the MMIO bus.
//
// Each channel copies BLOCK_BYTES-byte blocks from a 16-bit source address to a
// 16-bit destination address. A channel runs in one of two modes:
//   general : all blocks go back-to-back once the channel wins the bus
//   hblank  : one block per hblank rising edge seen while the channel is pending
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ct              T-cycle index inside the machine cycle (0..3)
//   mmio_a/din/wr   CPU register write port (mmio_wr already decoded upstream)
//   mmio_dout       combinational register read data for mmio_a
//   hblank          PPU hblank level; its rising edge triggers hblank-mode blocks
//   dma_a/dout/din  external bus address, write data, read data
//   dma_rd/dma_wr   bus strobes: read in ct 0/1, write in ct 2/3
//   dma_occupy_bus  high for every machine cycle of an active block
//   ch_active       per-channel busy flag
//   int_done        one-clk pulse per channel on completion or cancel
//
// Register map, channel c at MMIO_BASE+5c:
//   +0 SRC_HI  +1 SRC_LO  +2 DST_HI  +3 DST_LO  +4 CTRL ([7]=hblank mode, [LEN_W-1:0]=blocks-1)

// Per-channel registers and state machine.
//   wr_en/wr_off/wr_data  register write targeted at this channel
//   hb_edge               hblank rising edge this clk
//   grant                 arbiter hands this channel the next block
//   step                  end of a byte (ct==3) while this channel owns the bus
//   blk_done              last byte of this channel's block completes this clk
//   src/dst               current addresses
//   active/elig           busy flag / wants the bus at this arbitration point
//   ctrl_rd               CTRL read value
//   done                  completion or cancel this clk
module dma_multi_ch #(
  parameter int LEN_W = 7,
  parameter int BW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [7:0]  wr_data,
  input  logic        hb_edge,
  input  logic        grant,
  input  logic        step,
  input  logic        blk_done,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic        active,
  output logic        elig,
  output logic [7:0]  ctrl_rd,
  output logic        done
);
  // Low address bits inside a block are forced to zero on LO writes.
  localparam logic [7:0] LO_MASK = ~8'((1 << BW) - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_XFER} state_e;

  state_e           state_q, state_d;
  logic [15:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             armed_q, armed_d;
  logic             cancel_q, cancel_d;
  logic             ctrl_wr, cancel_wr, last_blk;

  assign ctrl_wr   = wr_en && (wr_off == 3'd4);
  // Only an hblank-mode channel can be cancelled; other active CTRL writes are dropped.
  assign cancel_wr = ctrl_wr && !wr_data[7] && mode_q && (state_q != S_IDLE);
  assign last_blk  = (cnt_q == '0) || cancel_q || cancel_wr;

  assign src    = src_q;
  assign dst    = dst_q;
  assign active = (state_q != S_IDLE);

  // A general-mode channel finishing a non-final block is eligible in the same
  // arbitration slot, so consecutive blocks run without a gap.
  assign elig = !cancel_wr &&
                (((state_q == S_PEND) && (!mode_q || armed_q)) ||
                 ((state_q == S_XFER) && blk_done && !last_blk && !mode_q));

  always_comb begin
    ctrl_rd = 8'hFF;
    if (state_q != S_IDLE) begin
      ctrl_rd              = '0;
      ctrl_rd[LEN_W-1:0]   = cnt_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    armed_d  = armed_q;
    cancel_d = cancel_q;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          case (wr_off)
            3'd0: src_d[15:8] = wr_data;
            3'd1: src_d[7:0]  = wr_data & LO_MASK;
            3'd2: dst_d[15:8] = wr_data;
            3'd3: dst_d[7:0]  = wr_data & LO_MASK;
            3'd4: begin
              state_d  = S_PEND;
              mode_d   = wr_data[7];
              cnt_d    = wr_data[LEN_W-1:0];
              armed_d  = 1'b0;
              cancel_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_PEND: begin
        if (cancel_wr) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else if (grant) begin
          state_d = S_XFER;
        end else if (hb_edge && mode_q) begin
          armed_d = 1'b1;
        end
      end
      S_XFER: begin
        if (cancel_wr) cancel_d = 1'b1;
        if (blk_done) begin
          if (last_blk) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
            done     = 1'b1;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            armed_d = 1'b0;
            state_d = grant ? S_XFER : S_PEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (step) begin
      src_d = src_q + 16'd1;
      dst_d = dst_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      armed_q  <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      armed_q  <= armed_d;
      cancel_q <= cancel_d;
    end
  end
endmodule

module dma_multi #(
  parameter int          NUM_CH      = 2,
  parameter logic [15:0] MMIO_BASE   = 16'hFF51,
  parameter int          LEN_W       = 7,
  parameter int          BLOCK_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ct,
  input  logic [15:0]       mmio_a,
  input  logic [7:0]        mmio_din,
  input  logic              mmio_wr,
  output logic [7:0]        mmio_dout,
  input  logic              hblank,
  output logic [15:0]       dma_a,
  output logic [7:0]        dma_dout,
  input  logic [7:0]        dma_din,
  output logic              dma_rd,
  output logic              dma_wr,
  output logic              dma_occupy_bus,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] int_done
);
  localparam int BW = $clog2(BLOCK_BYTES);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              busy_q, busy_d;
  logic [CW-1:0]     owner_q, owner_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              hblank_q;
  logic [NUM_CH-1:0] int_done_q;

  logic [NUM_CH-1:0]       sel, grant, elig, active, done, blk_done_v, step_v;
  logic [NUM_CH-1:0][15:0] src_v, dst_v;
  logic [NUM_CH-1:0][7:0]  ctrl_v;
  logic [NUM_CH-1:0][2:0]  off_v;
  logic                    hb_edge, mcyc_end, blk_done, arb_ok, found;

  assign hb_edge  = hblank && !hblank_q;
  assign mcyc_end = (ct == 2'd3);
  // byte_q counts bytes inside the block; all-ones is the last byte.
  assign blk_done = busy_q && mcyc_end && (&byte_q);
  assign arb_ok   = mcyc_end && (!busy_q || blk_done);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [15:0] diff;
    // Unsigned offset from the channel base; wrap-around makes <5 a range check.
    assign diff          = mmio_a - 16'(MMIO_BASE + 5 * c);
    assign sel[c]        = (diff < 16'd5);
    assign off_v[c]      = diff[2:0];
    assign blk_done_v[c] = blk_done && (owner_q == CW'(c));
    assign step_v[c]     = busy_q && mcyc_end && (owner_q == CW'(c));

    dma_multi_ch #(.LEN_W(LEN_W), .BW(BW)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (mmio_wr && sel[c]),
      .wr_off   (off_v[c]),
      .wr_data  (mmio_din),
      .hb_edge  (hb_edge),
      .grant    (grant[c]),
      .step     (step_v[c]),
      .blk_done (blk_done_v[c]),
      .src      (src_v[c]),
      .dst      (dst_v[c]),
      .active   (active[c]),
      .elig     (elig[c]),
      .ctrl_rd  (ctrl_v[c]),
      .done     (done[c])
    );
  end

  // Fixed priority: lowest eligible index wins; the bus is held for a whole block.
  always_comb begin
    grant   = '0;
    busy_d  = busy_q;
    owner_d = owner_q;
    found   = 1'b0;
    if (blk_done) busy_d = 1'b0;
    if (arb_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (elig[c] && !found) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          busy_d   = 1'b1;
          owner_d  = CW'(c);
        end
      end
    end
  end

  always_comb begin
    byte_d  = byte_q;
    rdata_d = rdata_q;
    if (busy_q && mcyc_end) byte_d = byte_q + 1'b1;
    if (busy_q && (ct == 2'd1)) rdata_d = dma_din;
  end

  always_comb begin
    dma_a    = '0;
    dma_dout = '0;
    if (busy_q) begin
      if (ct[1]) begin
        dma_a    = dst_v[owner_q];
        dma_dout = rdata_q;
      end else begin
        dma_a = src_v[owner_q];
      end
    end
  end

  assign dma_occupy_bus = busy_q;
  assign dma_rd         = busy_q && !ct[1];
  assign dma_wr         = busy_q && ct[1];
  assign ch_active      = active;
  assign int_done       = int_done_q;

  always_comb begin
    mmio_dout = 8'hFF;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel[c] && (off_v[c] == 3'd4)) mmio_dout = ctrl_v[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      owner_q    <= '0;
      byte_q     <= '0;
      rdata_q    <= '0;
      hblank_q   <= 1'b0;
      int_done_q <= '0;
    end else begin
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      byte_q     <= byte_d;
      rdata_q    <= rdata_d;
      hblank_q   <= hblank;
      int_done_q <= done;
    end
  end
endmodule
